plab4_net_router_sd_input_unit: RTL
===================================

Name: plab4_net_router_sd_input_unit

Overview:
- Parametrised security-domain (SD) input unit for one router input port (west or east).
- Each SD gets its own message queue.
- A time-division scheduler owns the port and decides which domain may dequeue toward the crossbar/input-ctrl.
- Generalises the two-domain, one-cycle-alternation scheme to N domains and multi-cycle slots, with optional dead cycles at the end of each slot.
- Steers in_rdy by the arriving message's domain, not the scheduled domain, and flags illegal domain IDs.

Parameters:
- p_msg_nbits, 41: network message width (payload 32, opaque 3, src 3, dest 3).
- p_num_domains, 2: number of security domains / per-domain queues; legal range 1..8.
- p_sd_nbits, 1: domain ID width; must be at least clog2(p_num_domains), minimum 1.
- p_num_msgs, 4: entries per domain queue; minimum 2.
- p_num_free_nbits, 3: width of the num_free output; must hold p_num_msgs.
- p_slot_cycles, 1: cycles each domain owns the dequeue side.
- p_dead_cycles, 0: final cycles of each slot in which dequeue is suppressed. Required: p_dead_cycles < p_slot_cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_val  in  1  upstream message valid.
- in_rdy  out  1  unit can accept in_msg into queue[in_sd].
- in_msg  in  p_msg_nbits  upstream message.
- in_sd  in  p_sd_nbits  security domain of in_msg.
- deq_val  out  1  head of queue[cur_sd] presented and dequeue window open.
- deq_rdy  in  1  downstream (input ctrl) accepts deq_msg.
- deq_msg  out  p_msg_nbits  head entry of queue[cur_sd].
- deq_sd  out  p_sd_nbits  currently scheduled domain (cur_sd).
- num_free  out  p_num_free_nbits  free entries in queue[cur_sd], used by terminal-ctrl deadlock avoidance.
- sd_err  out  1  sticky flag: in_val seen with in_sd >= p_num_domains.

Behaviour:
- Reset (synchronous): all queues empty, cur_sd=0, slot_cnt=0, sd_err=0. In the cycle after reset: deq_val=0, num_free=p_num_msgs, deq_sd=0, in_rdy=1 for any legal in_sd. deq_msg is don't-care while deq_val=0. Reset asserted mid-operation flushes every queue and drops queued messages; a message offered in the reset cycle is not enqueued.
- Scheduler:
  - slot_cnt counts 0..p_slot_cycles-1 and advances every cycle, independent of traffic.
  - On wrap, cur_sd <= (cur_sd == p_num_domains-1) ? 0 : cur_sd+1.
  - If p_slot_cycles=1, cur_sd changes every cycle.
  - If p_num_domains=1, cur_sd stays 0.
- Window: win = (slot_cnt < p_slot_cycles - p_dead_cycles).
- Dequeue:
  - deq_val = win & !empty[cur_sd].
  - deq_fire = deq_val & deq_rdy pops queue[cur_sd] at the clock edge.
  - deq_msg is combinational from the queue head (zero added latency).
  - deq_val must not depend on deq_rdy.
  - Queues other than cur_sd never pop.
- Enqueue:
  - legal = (in_sd < p_num_domains).
  - in_rdy = legal & !full[in_sd]; in_rdy is combinational from in_sd and the registered queue counts only.
  - enq_fire = in_val & in_rdy pushes in_msg into queue[in_sd].
  - Queues are normal, not bypass or pipe: a message enqueued in cycle t is dequeueable no earlier than t+1.
  - A full queue reports in_rdy=0 even if it dequeues in the same cycle.
- Simultaneous enq/deq on the same non-full, non-empty queue: both occur and the count is unchanged. FIFO order is strict per domain.
- Isolation: traffic in domain A never changes in_rdy, deq_val or num_free timing observed for domain B.
- num_free = p_num_msgs - count[cur_sd], sampled from registered state. It follows cur_sd, so its value switches at slot boundaries.
- sd_err: set when in_val & !legal; cleared only by reset. Illegal messages are never enqueued.
- Occupancy counters are clog2(p_num_msgs+1) bits wide; read/write pointers wrap modulo p_num_msgs (non-power-of-two depth supported).

Test Plan:
- Reset, then idle 6 cycles with p_num_domains=3, p_slot_cycles=2 -> deq_sd sequence 0,0,1,1,2,2; deq_val=0 throughout; num_free=4.
- Defaults: enq msg A (sd=0) and B (sd=1) back-to-back, deq_rdy=1 -> A appears on deq_msg only when deq_sd=0, B only when deq_sd=1, each exactly once, no earlier than the cycle after its enqueue.
- Fill queue[1] with 4 messages and hold deq_rdy=0 -> in_rdy=0 for in_sd=1, in_rdy=1 for in_sd=0, and num_free reads 0 in sd1 slots and 4 in sd0 slots.
- p_slot_cycles=4, p_dead_cycles=1, queue[0] holding 5 messages (p_num_msgs=8), deq_rdy=1 -> exactly 3 pops per sd0 slot, deq_val=0 in slot cycle 3.
- p_num_domains=3, in_val=1 with in_sd=3 -> no enqueue, sd_err=1 next cycle and stays 1 until reset.
- Reset pulsed with 2 messages queued mid-slot -> cycle after reset: deq_val=0, deq_sd=0, num_free=p_num_msgs; flushed messages never appear.

Source files
------------

// File: rtl/plab4_net_router_sd_input_unit.sv
// ---------------------------------------------------------------------------
// plab4_net_router_sd_input_unit
//
// Security-domain input unit for one router input port. Every security
// domain gets its own FIFO so that traffic in one domain can never block or
// reveal timing to another. A time-division scheduler hands the dequeue side
// to one domain at a time for p_slot_cycles cycles. The last p_dead_cycles
// cycles of each slot are kept idle so that a dequeue started by one domain
// cannot spill over into the next domain's slot.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset     synchronous, active-high; flushes every queue
//   in_val    upstream message valid
//   in_rdy    queue[in_sd] can take in_msg (depends on in_sd only)
//   in_msg    upstream message
//   in_sd     security domain of in_msg
//   deq_val   head of queue[cur_sd] presented and the window is open
//   deq_rdy   downstream accepts deq_msg
//   deq_msg   head entry of queue[cur_sd]
//   deq_sd    currently scheduled domain
//   num_free  free entries in queue[cur_sd]
//   sd_err    sticky: a message arrived with an out-of-range domain ID
// ---------------------------------------------------------------------------
module plab4_net_router_sd_input_unit #(
  parameter int p_msg_nbits      = 41,
  parameter int p_num_domains    = 2,
  parameter int p_sd_nbits       = 1,
  parameter int p_num_msgs       = 4,
  parameter int p_num_free_nbits = 3,
  parameter int p_slot_cycles    = 1,
  parameter int p_dead_cycles    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_msg_nbits-1:0]      in_msg,
  input  logic [p_sd_nbits-1:0]       in_sd,
  output logic                        deq_val,
  input  logic                        deq_rdy,
  output logic [p_msg_nbits-1:0]      deq_msg,
  output logic [p_sd_nbits-1:0]       deq_sd,
  output logic [p_num_free_nbits-1:0] num_free,
  output logic                        sd_err
);

  localparam int c_cnt_nbits  = $clog2(p_num_msgs + 1);
  localparam int c_ptr_nbits  = $clog2(p_num_msgs);
  localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;

  // Domain IDs are compared one bit wider so that a fully populated ID
  // space (p_num_domains == 2**p_sd_nbits) still yields a valid bound.
  localparam logic [p_sd_nbits:0]       c_num_domains = (p_sd_nbits+1)'(p_num_domains);
  localparam logic [p_sd_nbits-1:0]     c_last_sd     = p_sd_nbits'(p_num_domains - 1);
  localparam logic [c_slot_nbits-1:0]   c_last_slot   = c_slot_nbits'(p_slot_cycles - 1);
  localparam logic [c_slot_nbits:0]     c_win_cycles  = (c_slot_nbits+1)'(p_slot_cycles - p_dead_cycles);
  localparam logic [c_cnt_nbits-1:0]    c_depth       = c_cnt_nbits'(p_num_msgs);
  localparam logic [c_ptr_nbits-1:0]    c_last_ptr    = c_ptr_nbits'(p_num_msgs - 1);
  localparam logic [p_num_free_nbits-1:0] c_free_max  = p_num_free_nbits'(p_num_msgs);

  logic [c_slot_nbits-1:0] slot_cnt;
  logic [p_sd_nbits-1:0]   cur_sd;
  logic                    slot_wrap;
  logic                    win;

  logic [p_num_domains-1:0] full;
  logic [p_num_domains-1:0] empty;
  logic [p_num_domains-1:0] sel_in;
  logic [p_num_domains-1:0] sel_cur;
  logic [c_cnt_nbits-1:0]   count [p_num_domains];
  logic [p_msg_nbits-1:0]   head  [p_num_domains];

  logic                     legal;
  logic                     full_in;
  logic                     empty_cur;
  logic [c_cnt_nbits-1:0]   cnt_cur;
  logic [p_msg_nbits-1:0]   head_cur;
  logic                     enq_fire;
  logic                     deq_fire;

  // Scheduler: the slot counter free-runs regardless of traffic so that the
  // ownership pattern is fixed and cannot be modulated by any domain.
  assign slot_wrap = (slot_cnt == c_last_slot);
  assign win       = ({1'b0, slot_cnt} < c_win_cycles);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      cur_sd   <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + c_slot_nbits'(1);
      if (slot_wrap)
        cur_sd <= (cur_sd == c_last_sd) ? '0 : cur_sd + p_sd_nbits'(1);
    end
  end

  // One normal (non-bypass) FIFO per domain with modulo pointers so that
  // non-power-of-two depths work.
  for (genvar d = 0; d < p_num_domains; d++) begin : g_queue
    logic [p_msg_nbits-1:0] mem [p_num_msgs];
    logic [c_ptr_nbits-1:0] rd_ptr;
    logic [c_ptr_nbits-1:0] wr_ptr;
    logic [c_cnt_nbits-1:0] cnt;
    logic                   enq;
    logic                   deq;

    assign sel_in[d]  = ({1'b0, in_sd} == (p_sd_nbits+1)'(d));
    assign sel_cur[d] = (cur_sd == p_sd_nbits'(d));
    assign enq        = enq_fire & sel_in[d];
    assign deq        = deq_fire & sel_cur[d];
    assign count[d]   = cnt;
    assign full[d]    = (cnt == c_depth);
    assign empty[d]   = (cnt == '0);
    assign head[d]    = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (enq)
          wr_ptr <= (wr_ptr == c_last_ptr) ? '0 : wr_ptr + c_ptr_nbits'(1);
        if (deq)
          rd_ptr <= (rd_ptr == c_last_ptr) ? '0 : rd_ptr + c_ptr_nbits'(1);
        if (enq && !deq)
          cnt <= cnt + c_cnt_nbits'(1);
        else if (deq && !enq)
          cnt <= cnt - c_cnt_nbits'(1);
      end
    end

    // Storage needs no reset; the counters alone define what is valid.
    always_ff @(posedge clk) begin
      if (enq)
        mem[wr_ptr] <= in_msg;
    end
  end

  // Select the queue addressed by the arriving domain (enqueue side) and by
  // the scheduled domain (dequeue side). An illegal in_sd matches no queue.
  always_comb begin
    full_in   = 1'b0;
    empty_cur = 1'b1;
    cnt_cur   = '0;
    head_cur  = '0;
    for (int d = 0; d < p_num_domains; d++) begin
      if (sel_in[d])
        full_in = full[d];
      if (sel_cur[d]) begin
        empty_cur = empty[d];
        cnt_cur   = count[d];
        head_cur  = head[d];
      end
    end
  end

  // in_rdy depends only on in_sd and registered counts, so a full queue
  // stays not-ready even in a cycle where it also dequeues.
  assign legal    = ({1'b0, in_sd} < c_num_domains);
  assign in_rdy   = legal & ~full_in;
  assign enq_fire = in_val & in_rdy;

  assign deq_val  = win & ~empty_cur;
  assign deq_fire = deq_val & deq_rdy;
  assign deq_msg  = head_cur;
  assign deq_sd   = cur_sd;
  assign num_free = c_free_max - p_num_free_nbits'(cnt_cur);

  // Sticky illegal-domain flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      sd_err <= 1'b0;
    else if (in_val && !legal)
      sd_err <= 1'b1;
  end

endmodule
